// File: rtl/pps_gen_pkg.sv
// Shared types and constants for the PPS generator: FSM encoding, counter width,
// period/width floors and the clamp helpers used at every second boundary.
package pps_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int CNT_W   = 28;
    localparam int P_MIN   = 2;
    localparam int W_MIN   = 1;
    localparam int LEN_MAX = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t clamp_p(input cnt_t p);
        return (p < cnt_t'(P_MIN)) ? cnt_t'(P_MIN) : p;
    endfunction

    function automatic cnt_t clamp_w(input cnt_t w, input cnt_t p);
        cnt_t pc;
        pc = clamp_p(p);
        if (w < cnt_t'(W_MIN)) return cnt_t'(W_MIN);
        if (w >= pc) return pc - cnt_t'(1);
        return w;
    endfunction

    // Last counter index of a second; the adjusted length saturates so it never wraps the counter.
    function automatic cnt_t sec_last(input cnt_t p, input logic signed [7:0] adj, input logic use_adj);
        int len;
        len = int'(clamp_p(p));
        if (use_adj) len = len + int'(adj);
        if (len < P_MIN) len = P_MIN;
        if (len > LEN_MAX) len = LEN_MAX;
        return cnt_t'(len - 1);
    endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Three-flop synchronizer for the external PPS with a registered rising-edge strobe.
module pps_sync_edge (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_d,
    output logic o_rise
);

    logic [2:0] sync;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            sync   <= 3'b000;
            o_rise <= 1'b0;
        end else begin
            sync   <= {sync[1:0], i_d};
            o_rise <= (sync[2:1] == 2'b01);
        end
    end

endmodule

// File: rtl/pps_gen.sv
// Programmable PPS generator: free-running second counter with shadowed period/width,
// one-shot length adjust and re-alignment to an external PPS edge.
module pps_gen
    import pps_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned PW_DEFAULT = 10_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_res_n,
    input  logic                    i_en,
    input  logic [CNT_W-1:0]        i_period,
    input  logic [CNT_W-1:0]        i_width,
    input  logic                    i_cfg_stb,
    input  logic                    i_ext_pps,
    input  logic                    i_align_req,
    input  logic                    i_adj_stb,
    input  logic signed [7:0]       i_adj,
    output logic                    o_pps,
    output logic                    o_pps_stb,
    output logic                    o_aligned,
    output logic [31:0]             o_sec_cnt
);

    state_t            state, state_nxt;
    logic              rise, wrap, start;
    cnt_t              cnt, cnt_inc, cur_last, act_w, shd_p, shd_w;
    logic              adj_pend;
    logic signed [7:0] adj_val;

    pps_sync_edge u_sync (
        .i_clk  (i_clk),
        .i_res_n(i_res_n),
        .i_d    (i_ext_pps),
        .o_rise (rise)
    );

    assign cnt_inc = cnt + cnt_t'(1);
    assign wrap    = (state != IDLE) && (cnt == cur_last);
    // An alignment edge behaves as an early wrap, so a coincident wrap yields one pulse.
    assign start   = wrap || ((state == ARM) && rise);

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!i_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     if (i_align_req) state_nxt = ARM;
                ARM:     if (rise) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            cnt       <= '0;
            o_pps     <= 1'b0;
            o_pps_stb <= 1'b0;
            o_aligned <= 1'b0;
            o_sec_cnt <= '0;
            shd_p     <= cnt_t'(CLK_HZ);
            shd_w     <= cnt_t'(PW_DEFAULT);
            cur_last  <= sec_last(cnt_t'(CLK_HZ), 8'sd0, 1'b0);
            act_w     <= clamp_w(cnt_t'(PW_DEFAULT), cnt_t'(CLK_HZ));
            adj_pend  <= 1'b0;
            adj_val   <= '0;
        end else begin
            o_pps_stb <= 1'b0;
            if (i_cfg_stb) begin
                shd_p <= i_period;
                shd_w <= i_width;
            end
            if (i_en && start) adj_pend <= 1'b0;
            if (i_adj_stb) begin
                adj_pend <= 1'b1;
                adj_val  <= i_adj;
            end

            if (!i_en) begin
                cnt       <= '0;
                o_pps     <= 1'b0;
                o_aligned <= 1'b0;
            end else if (state == IDLE) begin
                // The enabling cycle is count 0 of an unpulsed first second.
                cnt      <= cnt_t'(1);
                o_pps    <= 1'b0;
                cur_last <= sec_last(shd_p, 8'sd0, 1'b0);
                act_w    <= clamp_w(shd_w, shd_p);
            end else if (start) begin
                cnt       <= '0;
                o_pps     <= 1'b1;
                o_pps_stb <= 1'b1;
                o_sec_cnt <= o_sec_cnt + 32'd1;
                cur_last  <= sec_last(shd_p, adj_val, adj_pend);
                act_w     <= clamp_w(shd_w, shd_p);
                if ((state == ARM) && rise) o_aligned <= 1'b1;
            end else begin
                cnt <= cnt_inc;
                if (cnt_inc >= act_w) o_pps <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pps_gen.sv
// Directed bench for pps_gen: table of period/width shapes plus hand-timed sequences
// for reset, adjust, config-at-wrap and external alignment.
module tb_pps_gen;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en, cfg_stb, ext_pps, align_req, adj_stb;
    logic [27:0]        period, width;
    logic signed [7:0]  adj;
    logic               pps, pps_stb, aligned;
    logic [31:0]        sec_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [27:0] p;
        logic [27:0] w;
        int          hi;
        int          len;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    pps_gen #(.CLK_HZ(16), .PW_DEFAULT(4)) dut (
        .i_clk      (clk),
        .i_res_n    (rst_n),
        .i_en       (en),
        .i_period   (period),
        .i_width    (width),
        .i_cfg_stb  (cfg_stb),
        .i_ext_pps  (ext_pps),
        .i_align_req(align_req),
        .i_adj_stb  (adj_stb),
        .i_adj      (adj),
        .o_pps      (pps),
        .o_pps_stb  (pps_stb),
        .o_aligned  (aligned),
        .o_sec_cnt  (sec_cnt)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_stb(output int n);
        n = 0;
        while (!pps_stb && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Called on a strobe sample; returns high time and length of that second.
    task automatic measure(output int hi, output int len);
        hi  = 0;
        len = 0;
        do begin
            if (pps) hi++;
            len++;
            tick();
        end while (!pps_stb && len < 200);
    endtask

    task automatic cfg(input logic [27:0] p, input logic [27:0] w);
        period  = p;
        width   = w;
        cfg_stb = 1'b1;
        tick();
        cfg_stb = 1'b0;
    endtask

    initial begin
        int n, hi, len;
        logic [31:0] s0;

        vecs[0] = '{p: 28'd10, w: 28'd3,  hi: 3, len: 10};
        vecs[1] = '{p: 28'd10, w: 28'd15, hi: 9, len: 10};
        vecs[2] = '{p: 28'd1,  w: 28'd1,  hi: 1, len: 2};
        vecs[3] = '{p: 28'd0,  w: 28'd0,  hi: 1, len: 2};
        vecs[4] = '{p: 28'd5,  w: 28'd0,  hi: 1, len: 5};
        vecs[5] = '{p: 28'd7,  w: 28'd7,  hi: 6, len: 7};

        rst_n = 1'b0; en = 1'b0; cfg_stb = 1'b0; ext_pps = 1'b0;
        align_req = 1'b0; adj_stb = 1'b0; period = '0; width = '0; adj = '0;
        ticks(3);
        chk("rst_pps", pps, 0);
        chk("rst_stb", pps_stb, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_sec_cnt", sec_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Defaults after reset: first pulse CLK_HZ clocks after enable, PW_DEFAULT high.
        en = 1'b1;
        wait_stb(n);
        chk("first_stb_latency", n, 16);
        chk("first_sec_cnt", sec_cnt, 1);
        measure(hi, len);
        chk("default_hi", hi, 4);
        chk("default_len", len, 16);

        // Asynchronous reset while the pulse is high.
        chk("pre_rst_pps", pps, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pps", pps, 0);
        chk("async_rst_stb", pps_stb, 0);
        chk("async_rst_sec_cnt", sec_cnt, 0);
        en = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();

        cfg(28'd10, 28'd3);
        en = 1'b1;
        wait_stb(n);
        chk("p10_first_latency", n, 10);
        chk("p10_sec_cnt1", sec_cnt, 1);
        measure(hi, len);
        chk("p10_hi", hi, 3);
        chk("p10_len", len, 10);
        chk("p10_sec_cnt2", sec_cnt, 2);
        measure(hi, len);
        chk("p10_sec_cnt3", sec_cnt, 3);

        for (int v = 0; v < 6; v++) begin
            en = 1'b0;
            tick();
            cfg(vecs[v].p, vecs[v].w);
            en = 1'b1;
            wait_stb(n);
            measure(hi, len);
            chk($sformatf("vec%0d_hi", v), hi, vecs[v].hi);
            chk($sformatf("vec%0d_len", v), len, vecs[v].len);
        end

        // Adjust: -5 overwritten by -3 before use, then one 7-clock second.
        en = 1'b0;
        tick();
        adj_stb = 1'b1; adj = -8'sd5;
        cfg(28'd10, 28'd3);
        adj = -8'sd3;
        tick();
        adj_stb = 1'b0;
        en = 1'b1;
        wait_stb(n);
        measure(hi, len);
        chk("adj_m3_len", len, 7);
        measure(hi, len);
        chk("adj_after_len", len, 10);
        adj_stb = 1'b1; adj = -8'sd9;
        tick();
        adj_stb = 1'b0;
        wait_stb(n);
        measure(hi, len);
        chk("adj_m9_len", len, 2);
        measure(hi, len);
        chk("adj_m9_after_len", len, 10);

        // Config strobe on the wrap edge: one more 10-clock second, then 20.
        ticks(9);
        period = 28'd20; width = 28'd3; cfg_stb = 1'b1;
        tick();
        cfg_stb = 1'b0;
        chk("cfg_wrap_stb", pps_stb, 1);
        measure(hi, len);
        chk("cfg_wrap_old_len", len, 10);
        measure(hi, len);
        chk("cfg_wrap_new_len", len, 20);

        // Alignment: ext edge after edge t gives o_pps at t+4.
        cfg(28'd10, 28'd3);
        chk("pre_align_aligned", aligned, 0);
        align_req = 1'b1;
        tick();
        align_req = 1'b0;
        ext_pps = 1'b1;
        ticks(3);
        chk("align_t3_stb", pps_stb, 0);
        tick();
        chk("align_t4_pps", pps, 1);
        chk("align_t4_stb", pps_stb, 1);
        chk("align_t4_aligned", aligned, 1);
        measure(hi, len);
        chk("align_next_len", len, 10);
        chk("align_next_hi", hi, 3);

        // Alignment edge landing on a natural wrap: one strobe, one count.
        ext_pps = 1'b0;
        s0 = sec_cnt;
        align_req = 1'b1;
        tick();
        align_req = 1'b0;
        ticks(5);
        ext_pps = 1'b1;
        ticks(4);
        chk("coinc_stb", pps_stb, 1);
        chk("coinc_sec_cnt", sec_cnt, s0 + 32'd1);
        tick();
        chk("coinc_stb_single", pps_stb, 0);
        chk("coinc_sec_cnt_once", sec_cnt, s0 + 32'd1);
        wait_stb(n);
        chk("coinc_next_wait", n, 9);

        // Disable during the pulse: outputs clear within one clock, count held.
        s0 = sec_cnt;
        en = 1'b0;
        tick();
        chk("dis_pps", pps, 0);
        chk("dis_stb", pps_stb, 0);
        chk("dis_aligned", aligned, 0);
        chk("dis_sec_cnt", sec_cnt, s0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
